// File: rtl/hex_printer.sv
// hex_printer: latches a value on request and writes it to a UART TX FIFO as
// uppercase ASCII hex, most significant nibble first, one byte per clock.
// Optional macro HEXPRINT_CRLF_EN appends CR LF (TAIL state) to each string.
//
// Handshake (FIFO write side): a byte is transferred in every cycle where
// wren_o=1; wren_o is only raised while full_i=0, and full_i gates it in the
// same cycle, so a write is never issued into a full FIFO. The index and
// state advance only on cycles where a byte is actually transferred.
module hex_printer #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [4*NIBBLES-1:0] value_i,
  input  logic                 send_i,
  output logic                 busy_o,
  output logic [7:0]           byte_o,
  output logic                 wren_o,
  input  logic                 full_i,
  output logic [1:0]           dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIGITS = 2'd1
`ifdef HEXPRINT_CRLF_EN
    ,S_TAIL  = 2'd2
`endif
  } state_t;

  localparam logic [3:0] LAST_DIGIT = 4'(NIBBLES - 1);
`ifdef HEXPRINT_CRLF_EN
  localparam logic [3:0] LAST_TAIL  = 4'(NIBBLES + 1);
`endif

  state_t               r_state;
  logic [3:0]           r_idx;
  logic [4*NIBBLES-1:0] r_shadow;
  logic                 r_busy;

  state_t               w_state_nx;
  logic [3:0]           w_idx_nx;
  logic                 w_load;
  logic                 w_wren;
  logic [4*NIBBLES-1:0] w_shift;
  logic [3:0]           w_digit;
  logic [7:0]           w_ascii;

  assign w_wren = (r_state != S_IDLE) & ~full_i;

  // Select the nibble at the current index by shifting it to the top.
  assign w_shift = r_shadow << {r_idx, 2'b00};
  assign w_digit = w_shift[4*NIBBLES-1 -: 4];
  assign w_ascii = (w_digit < 4'd10) ? (8'h30 + {4'h0, w_digit})
                                     : (8'h37 + {4'h0, w_digit});

  // Next-state and index logic; progress only on a transferred byte.
  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_load     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (send_i) begin
          w_load     = 1'b1;
          w_idx_nx   = 4'd0;
          w_state_nx = S_DIGITS;
        end
      end
      S_DIGITS: begin
        if (w_wren) begin
          w_idx_nx = r_idx + 4'd1;
          if (r_idx == LAST_DIGIT) begin
`ifdef HEXPRINT_CRLF_EN
            w_state_nx = S_TAIL;
`else
            w_state_nx = S_IDLE;
`endif
          end
        end
      end
`ifdef HEXPRINT_CRLF_EN
      S_TAIL: begin
        if (w_wren) begin
          w_idx_nx = r_idx + 4'd1;
          if (r_idx == LAST_TAIL) begin
            w_state_nx = S_IDLE;
          end
        end
      end
`endif
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Output character mux: digits, or CR/LF while in the tail.
  always_comb begin
    byte_o = w_ascii;
`ifdef HEXPRINT_CRLF_EN
    if (r_state == S_TAIL) begin
      byte_o = (r_idx == LAST_DIGIT + 4'd1) ? 8'h0D : 8'h0A;
    end
`endif
  end

  // State, index, shadow value and busy flag registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_idx    <= 4'd0;
      r_shadow <= '0;
      r_busy   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_idx   <= w_idx_nx;
      r_busy  <= (w_state_nx != S_IDLE);
      if (w_load) begin
        r_shadow <= value_i;
      end
    end
  end

  assign busy_o      = r_busy;
  assign wren_o      = w_wren;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_hex_printer.sv
// tb_hex_printer: table-driven strings plus hand sequences for back-to-back,
// ignored requests, asynchronous reset abort and an 8-digit instance.
module tb_hex_printer;

`ifdef HEXPRINT_CRLF_EN
  localparam int TAIL = 2;
`else
  localparam int TAIL = 0;
`endif
  localparam int LEN4 = 4 + TAIL;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] val4 = '0;
  logic        send4 = 1'b0;
  logic        full4 = 1'b0;
  logic        busy4, wren4;
  logic [7:0]  byte4;
  logic [1:0]  st4;
  logic [31:0] val8 = '0;
  logic        send8 = 1'b0;
  logic        full8 = 1'b0;
  logic        busy8, wren8;
  logic [7:0]  byte8;
  logic [1:0]  st8;

  int total = 0;
  int bad   = 0;
  int wr4   = 0;
  bit last4 = 1'b0;
  logic [7:0] q4[$];
  logic [7:0] q8[$];

  typedef struct {
    logic [15:0] value;
    int          stall_after;
    int          stall_len;
    logic [7:0]  exp [4];
  } vec_t;
  vec_t vecs [5];

  hex_printer #(.NIBBLES(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .value_i(val4), .send_i(send4),
    .busy_o(busy4), .byte_o(byte4), .wren_o(wren4), .full_i(full4),
    .dbg_state_o(st4)
  );

  hex_printer #(.NIBBLES(8)) u_dut8 (
    .clk_i(clk), .rst_i(rst), .value_i(val8), .send_i(send8),
    .busy_o(busy8), .byte_o(byte8), .wren_o(wren8), .full_i(full8),
    .dbg_state_o(st8)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_tail4();
`ifdef HEXPRINT_CRLF_EN
    q4.push_back(8'h0D);
    q4.push_back(8'h0A);
`endif
  endtask

  task automatic push_vec(input int i);
    for (int k = 0; k < 4; k++) q4.push_back(vecs[i].exp[k]);
    push_tail4();
  endtask

  task automatic wait_idle4(input string name);
    int c = 0;
    while (busy4 && c < 60) begin
      tick();
      c++;
    end
    if (busy4) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: busy still 1 after %0d cycles", name, c);
    end
  endtask

  // scoreboard for the 4-digit instance
  always @(negedge clk) begin
    if (!rst) begin
      if (last4) begin
        check("busy_after_last", {31'd0, busy4}, 32'd0);
        last4 = 1'b0;
      end
      if (busy4 && !full4 && q4.size() > 0)
        check("wren_when_ready", {31'd0, wren4}, 32'd1);
      if (wren4) begin
        if (q4.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_write4: got byte 0x%0h expected no write", byte4);
        end else begin
          check("byte4", {24'd0, byte4}, {24'd0, q4.pop_front()});
          wr4++;
          if (q4.size() == 0) last4 = 1'b1;
        end
      end
    end
  end

  // scoreboard for the 8-digit instance
  always @(negedge clk) begin
    if (!rst && wren8) begin
      if (q8.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_write8: got byte 0x%0h expected no write", byte8);
      end else begin
        check("byte8", {24'd0, byte8}, {24'd0, q8.pop_front()});
      end
    end
  end

  task automatic run_vec(input int i);
    int  start;
    int  c = 0;
    bit  stalled = 1'b0;
    push_vec(i);
    val4  = vecs[i].value;
    send4 = 1'b1;
    tick();
    send4 = 1'b0;
    val4  = 16'($urandom);
    check("busy_rise", {31'd0, busy4}, 32'd1);
    start = wr4 - 0;
    while (busy4 && c < 60) begin
      if (!stalled && vecs[i].stall_after >= 0 && (wr4 - start) == vecs[i].stall_after) begin
        stalled = 1'b1;
        full4 = 1'b1;
        for (int s = 0; s < vecs[i].stall_len; s++) begin
          #1;
          check("stall_wren", {31'd0, wren4}, 32'd0);
          check("stall_busy", {31'd0, busy4}, 32'd1);
          tick();
        end
        full4 = 1'b0;
      end else begin
        tick();
      end
      c++;
    end
    wait_idle4("vec");
    check("vec_writes", 32'(wr4 - start), 32'(LEN4));
    check("vec_queue_empty", 32'(q4.size()), 32'd0);
  endtask

  initial begin
    vecs[0] = '{value: 16'h1A2F, stall_after: -1, stall_len: 0, exp: '{8'h31, 8'h41, 8'h32, 8'h46}};
    vecs[1] = '{value: 16'h1A2F, stall_after:  2, stall_len: 3, exp: '{8'h31, 8'h41, 8'h32, 8'h46}};
    vecs[2] = '{value: 16'hC0DE, stall_after:  0, stall_len: 2, exp: '{8'h43, 8'h30, 8'h44, 8'h45}};
    vecs[3] = '{value: 16'h9B57, stall_after:  3, stall_len: 1, exp: '{8'h39, 8'h42, 8'h35, 8'h37}};
    vecs[4] = '{value: 16'h00AB, stall_after: -1, stall_len: 0, exp: '{8'h30, 8'h30, 8'h41, 8'h42}};

    // reset state
    #12;
    check("rst_busy4", {31'd0, busy4}, 32'd0);
    check("rst_wren4", {31'd0, wren4}, 32'd0);
    check("rst_byte4", {24'd0, byte4}, 32'h30);
    check("rst_state4", {30'd0, st4}, 32'd0);
    check("rst_byte8", {24'd0, byte8}, 32'h30);
    check("rst_wren8", {31'd0, wren8}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("idle_busy4", {31'd0, busy4}, 32'd0);

    // table-driven strings
    for (int i = 0; i < 4; i++) begin
      run_vec(i);
      tick();
    end

    // back-to-back requests with send held high
    begin
      int c = 0;
      for (int k = 0; k < 4; k++) q4.push_back(8'h30);
      push_tail4();
      for (int k = 0; k < 4; k++) q4.push_back(8'h46);
      push_tail4();
      val4  = 16'h0000;
      send4 = 1'b1;
      tick();
      val4 = 16'hFFFF;
      while (q4.size() > LEN4 && c < 60) begin
        tick();
        c++;
      end
      check("b2b_idle_gap", {31'd0, busy4}, 32'd0);
      tick();
      check("b2b_second_start", {31'd0, busy4}, 32'd1);
      send4 = 1'b0;
      wait_idle4("b2b");
      check("b2b_queue_empty", 32'(q4.size()), 32'd0);
      tick();
    end

    // request while busy is ignored
    q4.push_back(8'h31); q4.push_back(8'h32); q4.push_back(8'h33); q4.push_back(8'h34);
    push_tail4();
    val4  = 16'h1234;
    send4 = 1'b1;
    tick();
    send4 = 1'b0;
    tick();
    val4  = 16'hBEEF;
    send4 = 1'b1;
    tick();
    send4 = 1'b0;
    wait_idle4("ignore");
    check("ignore_queue_empty", 32'(q4.size()), 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("ignore_stay_idle", {31'd0, busy4}, 32'd0);
    end

    // asynchronous reset after two characters
    begin
      int start = wr4;
      int c = 0;
      push_vec(0);
      val4  = 16'h1A2F;
      send4 = 1'b1;
      tick();
      send4 = 1'b0;
      while ((wr4 - start) < 2 && c < 20) begin
        tick();
        c++;
      end
      #2;
      check("pre_reset_wren", {31'd0, wren4}, 32'd1);
      rst = 1'b1;
      #1;
      check("async_rst_wren", {31'd0, wren4}, 32'd0);
      check("async_rst_busy", {31'd0, busy4}, 32'd0);
      q4.delete();
      last4 = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      check("post_rst_busy", {31'd0, busy4}, 32'd0);
      run_vec(4);
      tick();
    end

    // 8-digit instance
    begin
      logic [7:0] e8 [8];
      e8 = '{8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46};
      for (int k = 0; k < 8; k++) q8.push_back(e8[k]);
`ifdef HEXPRINT_CRLF_EN
      q8.push_back(8'h0D);
      q8.push_back(8'h0A);
`endif
      val8  = 32'hDEADBEEF;
      send8 = 1'b1;
      tick();
      send8 = 1'b0;
      val8  = $urandom;
      for (int c = 0; c < 60 && busy8; c++) tick();
      check("dut8_idle", {31'd0, busy8}, 32'd0);
      check("dut8_queue_empty", 32'(q8.size()), 32'd0);
    end

    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hex_printer.md
# hex_printer

Upstream feeder for the FIFO-backed UART transmitter. It latches a binary value on request and converts it to uppercase ASCII hex characters, most significant nibble first, optionally followed by CR LF. It writes one character per clock into the transmitter's byte/write-enable/full interface and stalls while the FIFO reports full. Its typical use is debug printing of counters and register values over the serial line.

## Interface
- NIBBLES, default 4: number of hex digits printed; legal range 1..8. The value width is 4*NIBBLES bits.
- clk_i  input  1  system clock; same domain as the FIFO write side.
- rst_i  input  1  asynchronous, active-high reset.
- value_i  input  4*NIBBLES  value to print; sampled only on an accepted request.
- send_i  input  1  print request; level-sampled on each rising edge while idle.
- busy_o  output  1  high while a string is in progress.
- byte_o  output  8  ASCII character for the current position; meaningful only when wren_o is high.
- wren_o  output  1  write strobe to the FIFO; one byte is written per high cycle.
- full_i  input  1  FIFO full flag; no write is issued while it is high.

## Operation
- Reset is asynchronous and active-high.
- States:
  - IDLE: holds busy_o=0.
  - DIGITS: emits the digit characters.
  - TAIL: emits CR LF; exists only with the configuration macro.
- IDLE with send_i=1 at a rising edge:
  - Latches value_i into a shadow register.
  - Clears the character index to 0.
  - Moves to DIGITS.
- In IDLE with send_i=0, or in any non-IDLE state, send_i is ignored. Requests are neither queued nor counted.
- DIGITS, index k:
  - byte_o is the ASCII code of nibble [4*(NIBBLES-1-k)+3 : 4*(NIBBLES-1-k)].
  - Nibble 0..9 maps to 0x30..0x39; nibble A..F maps to 0x41..0x46.
- wren_o = (state != IDLE) & ~full_i. This is combinational from full_i, so the FIFO full flag is honoured in the same cycle.
- Each cycle with wren_o=1 advances the index by 1. While full_i=1 the index and state hold, so no character is skipped or duplicated.
- The last digit written leads to TAIL if configured, otherwise to IDLE.
- TAIL emits 0x0D, then 0x0A under the same write rule, then goes to IDLE.
- busy_o = (state != IDLE), registered.
- Index counter: 4 bits, wide enough for 8 digits plus 2 tail characters. The index does not wrap within a string.
- rst_i mid-string aborts the string immediately. No further writes occur, and the partial string is not resumed.

## Timing
- Reset values:
  - busy_o=0, wren_o=0.
  - byte_o=0x30, because the shadow register is 0 and the index is 0.
  - State IDLE.
- send_i sampled at edge E0: busy_o=1 and the first character is presented from the cycle after E0. wren_o is high in that cycle if full_i=0. Latency from request to first write is 1 cycle.
- Throughput: 1 byte per clock while full_i=0.
- The last write cycle is followed by busy_o=0 in the next cycle. The string occupies exactly NIBBLES (+2) write cycles plus any stall cycles.
- With send_i held high continuously, there is exactly 1 idle cycle (busy_o=0) between strings.
- full_i rising in the same cycle as a pending write suppresses that write; the same character is retried when full_i falls.

## Configuration
- HEXPRINT_CRLF_EN defined:
  - The TAIL state is compiled in.
  - Every string ends with 0x0D 0x0A.
  - String length is NIBBLES+2.
- Not defined:
  - TAIL is absent and strings contain digits only (length NIBBLES).
  - DIGITS returns directly to IDLE after the last digit.

## Test plan
- NIBBLES=4, value_i=0x1A2F, send_i pulse, full_i=0 -> wren_o high for consecutive cycles with bytes 0x31,0x41,0x32,0x46 (then 0x0D,0x0A with the macro). busy_o falls 1 cycle after the last write.
- Same value, full_i forced high for 3 cycles after the 2nd write -> wren_o low for those 3 cycles, then 0x32,0x46,... continue. Exactly one write per character.
- value_i=0x0000 then 0xFFFF, back-to-back requests -> 0x30 x4, then 0x46 x4 (with CR LF after each if the macro is defined). One idle cycle separates the strings.
- Request 0x1234; while busy, pulse send_i with 0xBEEF -> only "1234" is written; nothing from 0xBEEF. busy_o then stays 0.
- Assert rst_i asynchronously after 2 characters are written -> wren_o and busy_o drop to 0 without waiting for a clock edge. A new request for 0x00AB after release prints 0x30,0x30,0x41,0x42 in full.
- NIBBLES=8, value 0xDEADBEEF, without the macro -> 8 bytes 0x44,0x45,0x41,0x44,0x42,0x45,0x45,0x46. No 0x0D/0x0A is emitted.
